// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the two-requester UART transmit arbiter.
// State encoding and the default idle-lock timeout used by uart_tx_arbiter.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2,
        DRAIN = 2'd3
    } arb_state_t;

    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1024;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick2.sv
// Two-way round-robin pick: ptr=0 favours requester 0 on a tie, ptr=1 favours requester 1.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic ptr,
    output logic pick0,
    output logic pick1
);

    assign pick0 = req0 & (~req1 | ~ptr);
    assign pick1 = req1 & (~req0 |  ptr);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level arbiter sharing one UART transmitter between two byte requesters.
// Define UART_ARB_TIMEOUT_EN to revoke a lock held silent for TIMEOUT_CYCLES cycles.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_req,
    input  logic       req0_send,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_req,
    input  logic       req1_send,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    input  logic       uart_ready,
    output logic       uart_send,
    output logic [7:0] uart_data,
    output logic [1:0] grant
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("uart_tx_arbiter: TIMEOUT_CYCLES must be at least 2");
    end

    arb_state_t state;
    logic       ptr;
    logic       pending;
    logic       pick0;
    logic       pick1;
    logic       cap0;
    logic       cap1;
    logic       capture;
    logic [7:0] cap_data;
    logic       cap_last;
    logic       owner_req;
    logic       timeout_hit;

    rr_pick2 u_pick (
        .req0  (req0_req),
        .req1  (req1_req),
        .ptr   (ptr),
        .pick0 (pick0),
        .pick1 (pick1)
    );

    // A byte may only be offered once the previous one has left the arbiter.
    assign req0_ready = (state == LOCK0) & uart_ready & ~uart_send & ~pending;
    assign req1_ready = (state == LOCK1) & uart_ready & ~uart_send & ~pending;

    assign cap0      = req0_send & req0_ready;
    assign cap1      = req1_send & req1_ready;
    assign capture   = cap0 | cap1;
    assign cap_data  = cap1 ? req1_data : req0_data;
    assign cap_last  = cap1 ? req1_last : req0_last;
    assign owner_req = (state == LOCK1) ? req1_req : req0_req;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned     CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] idle_cnt;

    // Locks are only entered from IDLE, so clearing there covers lock entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (state == IDLE || capture) begin
            idle_cnt <= '0;
        end else if (state == LOCK0 || state == LOCK1) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign timeout_hit = (idle_cnt == CNT_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    // NOTE: all state and registered outputs update with non-blocking assignments so
    // every branch below sees the pre-edge values of state, uart_send and pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= 2'b00;
            uart_send <= 1'b0;
            uart_data <= 8'h00;
            pending   <= 1'b0;
            ptr       <= 1'b0;
        end else begin
            uart_send <= capture;
            pending   <= capture;
            if (capture) begin
                uart_data <= cap_data;
            end

            unique case (state)
                IDLE: begin
                    if (pick0) begin
                        state <= LOCK0;
                        grant <= 2'b01;
                        ptr   <= 1'b1;
                    end else if (pick1) begin
                        state <= LOCK1;
                        grant <= 2'b10;
                        ptr   <= 1'b0;
                    end
                end
                LOCK0, LOCK1: begin
                    if (capture) begin
                        if (cap_last) begin
                            state <= DRAIN;
                        end
                    end else if (!owner_req && !pending) begin
                        state <= IDLE;
                        grant <= 2'b00;
                    end else if (timeout_hit) begin
                        state <= IDLE;
                        grant <= 2'b00;
                        ptr   <= (state == LOCK0);
                    end
                end
                DRAIN: begin
                    // grant holds its owner until the last byte has been handed off.
                    if (uart_ready && !uart_send) begin
                        state <= IDLE;
                        grant <= 2'b00;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 2'b00;
                end
            endcase
        end
    end

endmodule
